// File: rtl/adc_err_mc.sv
// Multi-channel ADC-to-error stage: per-channel moving average, gain scaling, signed error vref - meas.
// Define ADC_ERR_SAT_EN to saturate err (and report sat); otherwise err wraps and sat stays 0.
module adc_err_mc #(
  parameter int ADC_W    = 12,
  parameter int CH       = 4,
  parameter int AVG_LOG2 = 3,
  parameter int GAIN_W   = 16,
  parameter int OUT_W    = 30,
  localparam int CW      = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    adc_ready,
  input  logic [ADC_W-1:0]        adc_data,
  input  logic [CW-1:0]           adc_ch,
  input  logic [GAIN_W-1:0]       gain,
  input  logic signed [OUT_W-1:0] vref,
  output logic [ADC_W-1:0]        adc_filt,
  output logic signed [OUT_W-1:0] meas,
  output logic signed [OUT_W-1:0] err,
  output logic [CW-1:0]           err_ch,
  output logic                    err_valid,
  output logic                    sat,
  output logic                    overrun
);

  localparam int DEPTH  = 2 ** AVG_LOG2;
  localparam int SUM_W  = ADC_W + AVG_LOG2;
  localparam int PROD_W = ADC_W + GAIN_W;
  localparam int NCODE  = 2 ** CW;

  typedef enum logic [2:0] {IDLE, CAP, FILT, CALC, OUT} state_t;

  state_t state_reg, state_next;

  logic sync1_reg, sync2_reg, sync3_reg;
  logic rise_det;

  logic [ADC_W-1:0]        data_reg;
  logic [CW-1:0]           ch_reg;
  logic [GAIN_W-1:0]       gain_reg;
  logic signed [OUT_W-1:0] vref_reg;
  logic [ADC_W-1:0]        filt_reg;

  logic [NCODE-1:0]        ch_used;
  logic [ADC_W-1:0]        old_sample [CH];
  logic [SUM_W-1:0]        ch_sum [CH];
  logic [SUM_W-1:0]        sum_next;
  logic [PROD_W-1:0]       prod;
  logic signed [OUT_W-1:0] meas_calc;
  logic signed [OUT_W-1:0] err_calc;
  logic                    sat_calc;

  // Two-flop synchronizer plus one history flop for the rising-edge detector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      sync3_reg <= 1'b0;
    end else begin
      sync1_reg <= adc_ready;
      sync2_reg <= sync1_reg;
      sync3_reg <= sync2_reg;
    end
  end

  assign rise_det = sync2_reg & ~sync3_reg;

  // Channel codes at or above CH are not backed by a filter and get dropped.
  for (genvar gi = 0; gi < NCODE; gi++) begin : g_used
    assign ch_used[gi] = (gi < CH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    overrun    = 1'b0;
    case (state_reg)
      IDLE:    if (rise_det) state_next = CAP;
      CAP:     state_next = ch_used[adc_ch] ? FILT : IDLE;
      FILT:    state_next = CALC;
      CALC:    state_next = OUT;
      OUT:     state_next = rise_det ? CAP : IDLE;
      default: state_next = IDLE;
    endcase
    // OUT hands straight back to CAP, so an edge there is taken rather than dropped.
    if (rise_det && (state_reg != IDLE) && (state_reg != OUT)) overrun = 1'b1;
  end

  assign err_valid = (state_reg == OUT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_reg <= '0;
      ch_reg   <= '0;
      gain_reg <= '0;
      vref_reg <= '0;
    end else if (state_reg == CAP) begin
      data_reg <= adc_data;
      ch_reg   <= adc_ch;
      gain_reg <= gain;
      vref_reg <= vref;
    end
  end

  // Each channel owns its sample ring, pointer and running sum.
  for (genvar gi = 0; gi < CH; gi++) begin : g_ch
    logic [ADC_W-1:0]    buf_reg [DEPTH];
    logic [AVG_LOG2-1:0] wp_reg;
    logic [SUM_W-1:0]    sum_reg;
    logic                wr_en;

    assign wr_en          = (state_reg == FILT) && (ch_reg == CW'(gi));
    assign old_sample[gi] = buf_reg[wp_reg];
    assign ch_sum[gi]     = sum_reg;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) buf_reg[i] <= '0;
        wp_reg  <= '0;
        sum_reg <= '0;
      end else if (wr_en) begin
        buf_reg[wp_reg] <= data_reg;
        wp_reg          <= wp_reg + AVG_LOG2'(1);
        sum_reg         <= sum_next;
      end
    end
  end

  assign sum_next = ch_sum[ch_reg] - SUM_W'(old_sample[ch_reg]) + SUM_W'(data_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     filt_reg <= '0;
    else if (state_reg == FILT)  filt_reg <= sum_next[SUM_W-1:AVG_LOG2];
  end

  assign prod      = PROD_W'(filt_reg) * PROD_W'(gain_reg);
  assign meas_calc = {{(OUT_W-PROD_W){1'b0}}, prod};

`ifdef ADC_ERR_SAT_EN
  logic signed [OUT_W:0] err_wide;

  assign err_wide = {vref_reg[OUT_W-1], vref_reg} - {1'b0, meas_calc};

  // Top two bits disagree exactly when the true difference leaves the OUT_W range.
  always_comb begin
    err_calc = err_wide[OUT_W-1:0];
    sat_calc = 1'b0;
    if (err_wide[OUT_W] != err_wide[OUT_W-1]) begin
      sat_calc = 1'b1;
      err_calc = err_wide[OUT_W] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end
`else
  assign err_calc = vref_reg - meas_calc;
  assign sat_calc = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      adc_filt <= '0;
      meas     <= '0;
      err      <= '0;
      err_ch   <= '0;
      sat      <= 1'b0;
    end else if (state_reg == CALC) begin
      adc_filt <= filt_reg;
      meas     <= meas_calc;
      err      <= err_calc;
      err_ch   <= ch_reg;
      sat      <= sat_calc;
    end
  end

endmodule

// File: tb/tb_adc_err_mc.sv
// Directed bench for adc_err_mc: a sample-history model predicts every result and its cycle.
module tb_adc_err_mc;
  // Five channels so that code 5 of the 3-bit channel field is an unused channel.
  localparam int CH_T = 5;
  localparam int CW_T = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            adc_ready = 1'b0;
  logic [11:0]     adc_data = '0;
  logic [CW_T-1:0] adc_ch = '0;
  logic [15:0]     gain = '0;
  logic [29:0]     vref = '0;
  logic [11:0]     adc_filt;
  logic [29:0]     meas;
  logic [29:0]     err;
  logic [CW_T-1:0] err_ch;
  logic            err_valid;
  logic            sat;
  logic            overrun;

  adc_err_mc #(.ADC_W(12), .CH(CH_T), .AVG_LOG2(3), .GAIN_W(16), .OUT_W(30)) dut (
    .clk(clk), .rst(rst), .adc_ready(adc_ready), .adc_data(adc_data), .adc_ch(adc_ch),
    .gain(gain), .vref(vref), .adc_filt(adc_filt), .meas(meas), .err(err),
    .err_ch(err_ch), .err_valid(err_valid), .sat(sat), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int              cyc;
    logic [11:0]     filt;
    logic [29:0]     meas;
    logic [29:0]     err;
    logic [CW_T-1:0] ch;
    logic            sat;
  } exp_t;

  exp_t exp_q[$];
  int   ovr_q[$];
  exp_t cur;
  int   hist [CH_T][$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input longint act, input longint expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d", nm, act, act, expv, expv, cyc);
    end
  endtask

  // Expected result = mean of the last 8 samples of the channel (missing ones count as 0).
  function automatic exp_t model(input int d, input int c, input int g, input longint vr, input int at);
    exp_t   e;
    longint s = 0;
    longint m;
    longint x;
    int     n;
    hist[c].push_back(d);
    n = hist[c].size();
    for (int i = (n > 8) ? n - 8 : 0; i < n; i++) s += hist[c][i];
    m = (s / 8) * g;
    x = vr - m;
    e.sat = 1'b0;
`ifdef ADC_ERR_SAT_EN
    if (x > 64'sd536870911) begin
      x = 64'sd536870911;
      e.sat = 1'b1;
    end else if (x < -64'sd536870912) begin
      x = -64'sd536870912;
      e.sat = 1'b1;
    end
`endif
    e.cyc  = at;
    e.filt = 12'(s / 8);
    e.meas = 30'(m);
    e.err  = 30'(x);
    e.ch   = CW_T'(c);
    return e;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    exp_q.delete();
    ovr_q.delete();
    for (int c = 0; c < CH_T; c++) hist[c].delete();
    cur.cyc = 0; cur.filt = '0; cur.meas = '0; cur.err = '0; cur.ch = '0; cur.sat = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    adc_ready = 1'b0;
    clear_model();
    tick(3);
    rst = 1'b0;
    tick(2);
  endtask

  // Pin rises at cycle base; synced edge lands at base+2, so err_valid is due at base+6.
  task automatic req(input int d, input int c, input int g, input longint vr);
    adc_data = 12'(d);
    adc_ch   = CW_T'(c);
    gain     = 16'(g);
    vref     = 30'(vr);
    tick(3);
    adc_ready = 1'b1;
    if (c < CH_T) exp_q.push_back(model(d, c, g, vr, cyc + 6));
    tick(3);
    adc_ready = 1'b0;
    tick(5);
    $display("req ch=%0d data=%0d gain=%0d vref=%0d -> filt=%0d meas=%0d err=%0d ch=%0d sat=%0b",
             c, d, g, vr, adc_filt, meas, $signed(err), err_ch, sat);
  endtask

  // Every cycle: valid/overrun timing, and outputs equal the last predicted result.
  initial begin
    bit exp_v;
    bit ovr_v;
    forever begin
      @(negedge clk);
      exp_v = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      if (exp_v) cur = exp_q.pop_front();
      ovr_v = (ovr_q.size() > 0) && (ovr_q[0] == cyc);
      if (ovr_v) void'(ovr_q.pop_front());
      chk("err_valid", longint'(err_valid), longint'(exp_v));
      chk("overrun", longint'(overrun), longint'(ovr_v));
      chk("adc_filt", longint'(adc_filt), longint'(cur.filt));
      chk("meas", longint'(meas), longint'(cur.meas));
      chk("err", longint'(err), longint'(cur.err));
      chk("err_ch", longint'(err_ch), longint'(cur.ch));
      chk("sat", longint'(sat), longint'(cur.sat));
    end
  end

  initial begin
    int base;
    clear_model();
    do_reset();
    chk("reset_filt", longint'(adc_filt), 0);
    chk("reset_err", longint'(err), 0);

    // Channel 0 step to 3050 against vref 3000.
    for (int i = 0; i < 9; i++) begin
      req(3050, 0, 1, 3000);
      if (i == 0) begin
        chk("step_first_filt", longint'(adc_filt), 381);
        chk("step_first_err", longint'($signed(err)), 2619);
      end
      if (i >= 7) begin
        chk("step_settled_filt", longint'(adc_filt), 3050);
        chk("step_settled_err", longint'($signed(err)), -50);
        chk("step_settled_ch", longint'(err_ch), 0);
      end
    end

    // Interleave ch0=3050 / ch1=100; ch1 starts empty and ramps independently.
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) req(3050, 0, 1, 3000);
      else            req(100, 1, 1, 3000);
      if (i == 14) chk("inter_ch0_filt", longint'(adc_filt), 3050);
      if (i == 15) begin
        chk("inter_ch1_filt", longint'(adc_filt), 100);
        chk("inter_ch1_ch", longint'(err_ch), 1);
      end
    end

    // Two pin rises 2 clk apart: the second lands in FILT and is dropped.
    adc_data = 12'd2000; adc_ch = 3'd3; gain = 16'd2; vref = 30'd0;
    tick(3);
    adc_ready = 1'b1;
    base = cyc;
    exp_q.push_back(model(2000, 3, 2, 0, base + 6));
    ovr_q.push_back(base + 4);
    tick(1); adc_ready = 1'b0;
    tick(1); adc_ready = 1'b1;
    tick(3); adc_ready = 1'b0;
    tick(6);
    $display("overrun pair -> filt=%0d err=%0d ch=%0d", adc_filt, $signed(err), err_ch);
    chk("ovr_filt", longint'(adc_filt), 250);
    chk("ovr_err", longint'($signed(err)), -500);

    // Unused channel code: no result, outputs hold, other channels untouched.
    req(1000, 5, 7, 123);
    chk("unused_hold_filt", longint'(adc_filt), 250);
    req(800, 2, 1, 0);
    chk("ch2_first_filt", longint'(adc_filt), 100);
    req(4000, 4, 1, 0);
    chk("ch4_first_filt", longint'(adc_filt), 500);
    req(100, 1, 1, 0);
    chk("ch1_after_unused", longint'(adc_filt), 100);
    req(2000, 3, 2, 0);
    chk("ch3_second_filt", longint'(adc_filt), 500);

    // Full-scale channel 0 with max gain against the most negative vref.
    for (int i = 0; i < 8; i++) req(4095, 0, 65535, -64'sd536870912);
    chk("sat_filt", longint'(adc_filt), 4095);
    chk("sat_meas", longint'(meas), 268365825);
`ifdef ADC_ERR_SAT_EN
    chk("sat_err", longint'(err), 64'h2000_0000);
    chk("sat_flag", longint'(sat), 1);
`else
    chk("wrap_err", longint'(err), 64'h1001_0FFF);
    chk("wrap_flag", longint'(sat), 0);
`endif

    // Reset during FILT of a ch0 sample: it must never produce a result.
    adc_data = 12'd800; adc_ch = 3'd0; gain = 16'd1; vref = 30'd0;
    tick(3);
    adc_ready = 1'b1;
    tick(4);
    do_reset();
    chk("midrst_filt", longint'(adc_filt), 0);
    chk("midrst_meas", longint'(meas), 0);
    chk("midrst_err", longint'(err), 0);
    req(800, 0, 1, 0);
    chk("post_rst_filt", longint'(adc_filt), 100);
    chk("post_rst_err", longint'($signed(err)), -100);

    tick(10);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
